// File: rtl/hann_win_pkg.sv
// hann_win_pkg: shared types and constants for the Hann windowing sequencer.
//   state_e      : sequencer states (IDLE, RUN, DRAIN)
//   round_const  : half-LSB rounding constant for a given number of fraction bits
//   SAT_MAX/MIN  : signed 16-bit output clamp bounds
package hann_win_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int SAT_MAX    = (2 ** (DATA_W_DEF - 1)) - 1;
  localparam int SAT_MIN    = -(2 ** (DATA_W_DEF - 1));

  // Added before the arithmetic shift so the result rounds half-up.
  function automatic int round_const(input int frac);
    return 1 << (frac - 1);
  endfunction

endpackage

// File: rtl/hann_win_mac.sv
// hann_win_mac: output stage of the windowing pipeline. Multiplies a signed
// sample by an unsigned Q1.15 coefficient, rounds half-up, saturates to the
// signed 16-bit range and registers the result with its frame markers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en_i              pipeline advance (output register loads when high)
//   valid_i           stage-1 holds a sample
//   sample_i, coef_i  signed sample, unsigned coefficient
//   first_i, last_i   frame markers of the stage-1 sample
//   valid_o, data_o   registered windowed sample
//   first_o, last_o   registered frame markers
//   sat_o             sticky: some loaded product was clipped
module hann_win_mac
  import hann_win_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_FRAC  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic        [DATA_WIDTH-1:0] coef_i,
  input  logic                         first_i,
  input  logic                         last_i,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         first_o,
  output logic                         last_o,
  output logic                         sat_o
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam logic signed [PW-1:0] MAX_P = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] MIN_P = PW'(SAT_MIN);
  localparam logic signed [PW-1:0] RND_P = PW'(round_const(COEF_FRAC));

  logic signed [PW-1:0]         prod, rnd, shf;
  logic                         clip_hi, clip_lo;
  logic signed [DATA_WIDTH-1:0] y_d;

  logic                         valid_q, first_q, last_q, sat_q;
  logic signed [DATA_WIDTH-1:0] data_q;

  always_comb begin
    // Coefficient is unsigned, so it gets a zero sign bit before the multiply.
    prod    = PW'(sample_i) * PW'($signed({1'b0, coef_i}));
    rnd     = prod + RND_P;
    shf     = rnd >>> COEF_FRAC;
    clip_hi = (shf > MAX_P);
    clip_lo = (shf < MIN_P);
    if (clip_hi)      y_d = DATA_WIDTH'(SAT_MAX);
    else if (clip_lo) y_d = DATA_WIDTH'(SAT_MIN);
    else              y_d = shf[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q  <= y_d;
        first_q <= first_i;
        last_q  <= last_i;
        if (clip_hi || clip_lo) sat_q <= 1'b1;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/hann_window_ctrl.sv
// hann_window_ctrl: streaming Hann windowing sequencer. Indexes each accepted
// sample within its frame, reads the matching coefficient from the external
// HANN_LUT single-port RAM (1-cycle registered read) and emits the windowed
// sample with first/last frame markers.
// Build option: define HANN_WIN_HALF_LUT_EN when the LUT holds only the first
// half of the (symmetric) window; indices are then folded into that half.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   win_en, frame_sync        start/continue level, frame restart pulse
//   s_valid/s_ready/s_data    input sample stream
//   m_valid/m_ready/m_data    windowed output stream, m_first/m_last markers
//   lut_addr/lut_rd_data      LUT read port, lut_wr_en tied low
//   busy, sat_flag            activity and sticky saturation status
//   dbg_state                 current sequencer state
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never depends on ready, and data/markers hold while valid is
// high and ready is low.
module hann_window_ctrl
  import hann_win_pkg::*;
#(
  parameter int FRAME_LEN  = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_FRAC  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         win_en,
  input  logic                         frame_sync,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_first,
  output logic                         m_last,
  output logic        [ADDR_WIDTH-1:0] lut_addr,
  input  logic        [DATA_WIDTH-1:0] lut_rd_data,
  output logic                         lut_wr_en,
  output logic                         busy,
  output logic                         sat_flag,
  output state_e                       dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

  function automatic logic [ADDR_WIDTH-1:0] lut_map(input logic [ADDR_WIDTH-1:0] i);
`ifdef HANN_WIN_HALF_LUT_EN
    return (i < ADDR_WIDTH'(FRAME_LEN / 2)) ? i : (LAST_IDX - i);
`else
    return i;
`endif
  endfunction

  state_e                       state_q, state_d;
  logic        [ADDR_WIDTH-1:0] idx_q, idx_d, idx_adv;
  logic                         s1_valid_q;
  logic signed [DATA_WIDTH-1:0] s1_data_q;
  logic        [ADDR_WIDTH-1:0] s1_idx_q;
  logic                         pipe_en, accept;

  always_comb begin
    pipe_en = !m_valid || m_ready;
    s_ready = pipe_en && (state_q != IDLE);
    accept  = s_valid && s_ready;

    // frame_sync wins over the increment: the accepted sample keeps the old
    // index, the following one is index 0.
    if (frame_sync)      idx_adv = '0;
    else if (accept)     idx_adv = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_WIDTH'(1);
    else                 idx_adv = idx_q;

    state_d = state_q;
    idx_d   = idx_adv;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (win_en) state_d = RUN;
      end
      // Leaving RUN looks at the post-accept index so a sample taken in the
      // same cycle is not stranded at the start of a partial frame.
      RUN:     if (!win_en) state_d = (idx_adv == '0) ? IDLE : DRAIN;
      DRAIN:   if (idx_adv == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // While stalled the RAM re-reads the stage-1 index so its output stays valid.
    lut_addr = lut_map(pipe_en ? idx_q : s1_idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pipe_en) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_data_q <= s_data;
          s1_idx_q  <= idx_q;
        end
      end
    end
  end

  hann_win_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_FRAC  (COEF_FRAC)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en_i     (pipe_en),
    .valid_i  (s1_valid_q),
    .sample_i (s1_data_q),
    .coef_i   (lut_rd_data),
    .first_i  (s1_idx_q == '0),
    .last_i   (s1_idx_q == LAST_IDX),
    .valid_o  (m_valid),
    .data_o   (m_data),
    .first_o  (m_first),
    .last_o   (m_last),
    .sat_o    (sat_flag)
  );

  assign lut_wr_en = 1'b0;
  assign busy      = (state_q != IDLE) || s1_valid_q || m_valid;
  assign dbg_state = state_q;

endmodule
